// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the timekeeping/button logic and the alarm
// sequencing controller. The master side supplies time, buttons and
// settings; the slave side (the controller) returns tone enable and status.
interface alarm_ctrl_if;
  logic       sec_tick;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       arm;
  logic       inc_hr;
  logic       inc_min;
  logic       snooze;
  logic       stop;
  logic       alarm_enable;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       snoozing;
  logic [1:0] snooze_left;

  modport master (
    output sec_tick, cur_hr, cur_min, cur_sec, arm,
    output inc_hr, inc_min, snooze, stop,
    input  alarm_enable, alarm_hr, alarm_min, snoozing, snooze_left
  );

  modport slave (
    input  sec_tick, cur_hr, cur_min, cur_sec, arm,
    input  inc_hr, inc_min, snooze, stop,
    output alarm_enable, alarm_hr, alarm_min, snoozing, snooze_left
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller. Holds the programmable alarm time, compares
// it with the running clock once per second and sequences ringing, snooze,
// stop, disarm and the ring auto-timeout. alarm_enable drives the tone
// generator enable directly, so it comes straight from a flop.
module alarm_ctrl #(
  parameter int RING_SEC       = 60,
  parameter int SNOOZE_SEC     = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int ALARM_HR_INIT  = 6,
  parameter int ALARM_MIN_INIT = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_ctrl_if.slave  bus
);

  // Timers count 0..LIMIT-1; the tick that would reach LIMIT causes the
  // transition instead, so the counter never has to hold LIMIT itself.
  localparam int RING_W = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
  localparam int SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
  localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
  localparam logic [1:0]        SNZ_FULL  = 2'(MAX_SNOOZE);
  localparam logic [4:0]        HR_INIT   = 5'(ALARM_HR_INIT);
  localparam logic [5:0]        MIN_INIT  = 6'(ALARM_MIN_INIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t            state;
  logic [RING_W-1:0] ring_timer;
  logic [SNZ_W-1:0]  snz_timer;
  logic [1:0]        snooze_left_q;
  logic [4:0]        alarm_hr_q;
  logic [5:0]        alarm_min_q;
  logic              alarm_enable_q;
  logic              snoozing_q;

  logic              time_match;
  logic              ring_expired;
  logic              snz_expired;
  logic              edit_ok;
  logic              snooze_avail;

  // Match fires only on the tick of second 0, so a stopped alarm cannot
  // retrigger later in the same minute.
  assign time_match   = bus.sec_tick && (bus.cur_sec == 6'd0) &&
                        (bus.cur_hr == alarm_hr_q) && (bus.cur_min == alarm_min_q);
  assign ring_expired = bus.sec_tick && (ring_timer == RING_LAST);
  assign snz_expired  = bus.sec_tick && (snz_timer == SNZ_LAST);
  assign edit_ok      = (state == IDLE) || (state == ARMED);
  assign snooze_avail = (snooze_left_q != 2'd0);

  // Sequencing FSM; outputs are set alongside each state change so they
  // always reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ring_timer     <= '0;
      snz_timer      <= '0;
      snooze_left_q  <= SNZ_FULL;
      alarm_enable_q <= 1'b0;
      snoozing_q     <= 1'b0;
    end else if (!bus.arm) begin
      // Disarm overrides everything else and returns to a clean slate.
      state          <= IDLE;
      ring_timer     <= '0;
      snz_timer      <= '0;
      snooze_left_q  <= SNZ_FULL;
      alarm_enable_q <= 1'b0;
      snoozing_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch reads the
      // pre-edge values of state, timers and the alarm time.
      case (state)
        IDLE: begin
          state <= ARMED;
        end

        ARMED: begin
          if (time_match) begin
            state          <= RINGING;
            ring_timer     <= '0;
            alarm_enable_q <= 1'b1;
          end
        end

        RINGING: begin
          if (bus.stop) begin
            state          <= ARMED;
            ring_timer     <= '0;
            snz_timer      <= '0;
            snooze_left_q  <= SNZ_FULL;
            alarm_enable_q <= 1'b0;
          end else if (bus.snooze && snooze_avail) begin
            state          <= SNOOZE;
            snz_timer      <= '0;
            snooze_left_q  <= snooze_left_q - 2'd1;
            alarm_enable_q <= 1'b0;
            snoozing_q     <= 1'b1;
          end else if (ring_expired) begin
            state          <= ARMED;
            ring_timer     <= '0;
            snooze_left_q  <= SNZ_FULL;
            alarm_enable_q <= 1'b0;
          end else if (bus.sec_tick) begin
            ring_timer <= ring_timer + RING_ONE;
          end
        end

        SNOOZE: begin
          if (bus.stop) begin
            state         <= ARMED;
            ring_timer    <= '0;
            snz_timer     <= '0;
            snooze_left_q <= SNZ_FULL;
            snoozing_q    <= 1'b0;
          end else if (snz_expired) begin
            state          <= RINGING;
            ring_timer     <= '0;
            snz_timer      <= '0;
            alarm_enable_q <= 1'b1;
            snoozing_q     <= 1'b0;
          end else if (bus.sec_tick) begin
            snz_timer <= snz_timer + SNZ_ONE;
          end
        end

        default: begin
          state          <= IDLE;
          ring_timer     <= '0;
          snz_timer      <= '0;
          snooze_left_q  <= SNZ_FULL;
          alarm_enable_q <= 1'b0;
          snoozing_q     <= 1'b0;
        end
      endcase
    end
  end

  // Alarm-time editing, allowed only while not ringing or snoozing. A match
  // in the same cycle still sees the old value because it is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_hr_q  <= HR_INIT;
      alarm_min_q <= MIN_INIT;
    end else if (edit_ok) begin
      if (bus.inc_hr) begin
        alarm_hr_q <= (alarm_hr_q == 5'd23) ? 5'd0 : alarm_hr_q + 5'd1;
      end
      // Minute wrap deliberately does not carry into the hour.
      if (bus.inc_min) begin
        alarm_min_q <= (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
      end
    end
  end

  assign bus.alarm_enable = alarm_enable_q;
  assign bus.snoozing     = snoozing_q;
  assign bus.snooze_left  = snooze_left_q;
  assign bus.alarm_hr     = alarm_hr_q;
  assign bus.alarm_min    = alarm_min_q;

endmodule
